// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM arbiter for the hiscore engine: steals one RAM cycle during a settled
// vblank window, when the CPU is idle, or after pausing the CPU on timeout.
module hiscore_ram_arbiter #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vblank,
    input  logic       cpu_busy,
    input  logic       cpu_halted,
    input  logic       hs_req,
    input  logic       hs_we,
    input  logic [9:0] hs_addr,
    input  logic [7:0] hs_wdata,
    output logic       hs_ack,
    output logic [7:0] hs_rdata,
    output logic       ram_sel,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       cpu_pause,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        CAPTURE,
        ACK
    } state_t;

    localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
    localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

    state_t      state_q, state_d;
    logic        req_we_q, req_we_d;
    logic [9:0]  req_addr_q, req_addr_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic [11:0] wait_q, wait_d;
    logic [3:0]  settle_q, settle_d;
    logic        armed_q, armed_d;
    logic        vblank_prev_q, vblank_prev_d;
    logic        hs_ack_q, hs_ack_d;
    logic [7:0]  hs_rdata_q, hs_rdata_d;
    logic        ram_sel_q, ram_sel_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic        cpu_pause_q, cpu_pause_d;
    logic        busy_q, busy_d;

    logic vblank_rise;
    logic vblank_open;
    logic window;

    // The window opens SETTLE cycles after the rising edge and closes in the same cycle vblank drops.
    always_comb begin
        vblank_rise   = vblank & ~vblank_prev_q;
        vblank_prev_d = vblank;
        settle_d      = settle_q;
        armed_d       = armed_q;
        if (!vblank) begin
            armed_d  = 1'b0;
            settle_d = 4'd0;
        end else if (vblank_rise) begin
            armed_d  = 1'b1;
            settle_d = 4'd1;
        end else if (armed_q && (settle_q < SETTLE_C)) begin
            settle_d = settle_q + 4'd1;
        end
        vblank_open = vblank & (vblank_rise ? (SETTLE_C == 4'd0)
                                            : (armed_q & (settle_q >= SETTLE_C)));
        window      = (vblank_open & ~cpu_busy) | cpu_halted;
    end

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        wait_d      = wait_q;
        cpu_pause_d = cpu_pause_q;
        hs_rdata_d  = hs_rdata_q;

        case (state_q)
            IDLE: begin
                if (hs_req) begin
                    req_we_d    = hs_we;
                    req_addr_d  = hs_addr;
                    req_wdata_d = hs_wdata;
                    wait_d      = 12'd0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!hs_req) begin
                    cpu_pause_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    if (wait_q != TIMEOUT_C) begin
                        wait_d = wait_q + 12'd1;
                    end
                    if (wait_d == TIMEOUT_C) begin
                        cpu_pause_d = 1'b1;
                    end
                    if (window) begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!req_we_q) begin
                    hs_rdata_d = ram_rdata;
                end
                state_d = ACK;
            end
            ACK: begin
                cpu_pause_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state they describe.
        hs_ack_d    = (state_d == ACK);
        ram_sel_d   = (state_d == ACCESS);
        ram_we_d    = (state_d == ACCESS) & req_we_q;
        ram_addr_d  = ram_sel_d ? req_addr_q  : ram_addr_q;
        ram_wdata_d = ram_sel_d ? req_wdata_q : ram_wdata_q;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            req_we_q      <= 1'b0;
            req_addr_q    <= 10'd0;
            req_wdata_q   <= 8'd0;
            wait_q        <= 12'd0;
            settle_q      <= 4'd0;
            armed_q       <= 1'b0;
            vblank_prev_q <= 1'b1;
            hs_ack_q      <= 1'b0;
            hs_rdata_q    <= 8'd0;
            ram_sel_q     <= 1'b0;
            ram_addr_q    <= 10'd0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= 8'd0;
            cpu_pause_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_we_q      <= req_we_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            wait_q        <= wait_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            vblank_prev_q <= vblank_prev_d;
            hs_ack_q      <= hs_ack_d;
            hs_rdata_q    <= hs_rdata_d;
            ram_sel_q     <= ram_sel_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            cpu_pause_q   <= cpu_pause_d;
            busy_q        <= busy_d;
        end
    end

    assign hs_ack    = hs_ack_q;
    assign hs_rdata  = hs_rdata_q;
    assign ram_sel   = ram_sel_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_pause = cpu_pause_q;
    assign busy      = busy_q;

endmodule

// File: doc/hiscore_ram_arbiter.md
HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning clk cycles after vblank rising edge before the access window opens (range 0-15).
REQ-002 The block SHALL have parameter TIMEOUT, default 4095, meaning WAIT-state cycles before CPU pause is requested (12-bit, range 1-4095).
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 vblank  in  1  video vertical blank, synchronous to clk.
REQ-006 cpu_busy  in  1  look-ahead: CPU will access work RAM in the next cycle.
REQ-007 cpu_halted  in  1  CPU acknowledges pause; RAM port free.
REQ-008 hs_req  in  1  hiscore engine access request, held until hs_ack.
REQ-009 hs_we  in  1  1 = write, 0 = read; sampled with hs_req in IDLE.
REQ-010 hs_addr  in  10  work-RAM byte address.
REQ-011 hs_wdata  in  8  write data.
REQ-012 hs_ack  out  1  one-cycle completion pulse.
REQ-013 hs_rdata  out  8  read data, valid while hs_ack is high, held afterwards.
REQ-014 ram_sel  out  1  steers RAM port to the arbiter.
REQ-015 ram_addr  out  10  RAM address.
REQ-016 ram_we  out  1  RAM write strobe.
REQ-017 ram_wdata  out  8  RAM write data.
REQ-018 ram_rdata  in  8  RAM read data, one-cycle synchronous latency.
REQ-019 cpu_pause  out  1  request to halt CPU.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states SHALL be IDLE, WAIT, ACCESS, CAPTURE and ACK.
REQ-022 In IDLE with hs_req=1, the block SHALL latch hs_we, hs_addr and hs_wdata and go to WAIT.
REQ-023 window SHALL be (vblank_open & ~cpu_busy) | cpu_halted, evaluated in WAIT.
REQ-024 vblank_open SHALL rise SETTLE cycles after a vblank rising edge and clear in the cycle vblank falls.
REQ-025 WAIT SHALL go to ACCESS when window=1.
REQ-026 If hs_req drops while in WAIT, the block SHALL return to IDLE with no hs_ack and no RAM cycle.
REQ-027 In ACCESS, ram_sel SHALL be 1 and ram_addr SHALL equal the latched address; ram_we SHALL equal the latched we for exactly this one cycle; ram_wdata SHALL equal the latched data.
REQ-028 ACCESS SHALL always proceed to CAPTURE, even if vblank falls or cpu_busy rises.
REQ-029 In CAPTURE, for reads only, the block SHALL register ram_rdata into hs_rdata; ram_sel and ram_we SHALL be 0.
REQ-030 In ACK, hs_ack SHALL be 1 for one cycle and the next state SHALL be IDLE.
REQ-031 Minimum latency SHALL be 4 cycles: hs_req sampled in IDLE at cycle 0 gives hs_ack in cycle 4.
REQ-032 A request held high through ACK SHALL be accepted as a new request in the following IDLE cycle.
REQ-033 The wait counter SHALL clear on entering WAIT, increment each WAIT cycle, and saturate at TIMEOUT.
REQ-034 At TIMEOUT, cpu_pause SHALL be registered high and held until ACK or a WAIT cancel, then cleared in the next cycle.
REQ-035 A write SHALL leave hs_rdata unchanged.
REQ-036 All outputs SHALL be registered; ram_addr and ram_wdata SHALL hold their last value outside ACCESS.

Reset
REQ-037 While reset_n=0, the block SHALL force the state to IDLE and hs_ack, hs_rdata, ram_sel, ram_addr, ram_we, ram_wdata, cpu_pause, busy, the wait counter and the settle counter to 0, asynchronously.
REQ-038 Reset asserted mid-ACCESS SHALL drop ram_we and ram_sel immediately, and the request SHALL be discarded.
REQ-039 After reset_n rises, vblank_open SHALL require a fresh vblank rising edge.

Verification
REQ-040 Read in window: vblank high for more than 2 cycles, cpu_busy=0, read request to addr 0x3A5 with RAM returning 0x5C -> ram_sel=1 for 1 cycle with ram_addr=0x3A5, then hs_ack in cycle 4 with hs_rdata=0x5C.
REQ-041 Write blocked: vblank=1, cpu_busy=1 for 10 cycles, write request 0x012=0xA7 -> no ram_we during those cycles; after cpu_busy falls, ram_we=1 for one cycle with ram_wdata=0xA7, then hs_ack.
REQ-042 Settle: request pending, vblank rises at cycle T -> ACCESS not before cycle T+2.
REQ-043 Timeout: TIMEOUT=16, vblank=0, request pending -> cpu_pause=1 after 16 WAIT cycles; cpu_halted=1 -> access completes and cpu_pause=0 the cycle after ACK.
REQ-044 Cancel and reset: hs_req dropped in WAIT -> IDLE, no hs_ack; separately, reset_n=0 during ACCESS -> ram_we=0 and busy=0 at once.
REQ-045 Back-to-back: hs_req held high for 3 reads -> 3 hs_ack pulses exactly 5 cycles apart when the window stays open.
